// File: rtl/pe_row_pkg.sv
// pe_row shared constants and helpers.
// Default geometry of the PE row plus a clog2 for width checks.
package pe_row_pkg;

  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_NUM_MACS        = 4;
  localparam int DEF_NUM_PES_PER_ROW = 4;
  localparam int DEF_ACC_WIDTH       = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

  function automatic int acc_min(input int dw, input int nm);
    return 2 * dw + clog2(nm);
  endfunction

endpackage

// File: rtl/pe_row_pe.sv
// Single PE: NUM_MACS unsigned multipliers, adder tree, accumulator.
// Result lane is the low DATA_WIDTH bits of the accumulator register.
module pe
  import pe_row_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_MACS   = DEF_NUM_MACS,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rst_acc,
  input  logic                           clk_en,
  input  logic [NUM_MACS*DATA_WIDTH-1:0] a,
  input  logic [NUM_MACS*DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0]          result
);

  localparam int PW = 2 * DATA_WIDTH;

  generate
    if (ACC_WIDTH < acc_min(DATA_WIDTH, NUM_MACS)) begin : g_bad_acc
      $error("pe: ACC_WIDTH too small for DATA_WIDTH/NUM_MACS");
    end
  endgenerate

  logic [PW-1:0]        prod [NUM_MACS];
  logic [ACC_WIDTH-1:0] dot;
  logic [ACC_WIDTH-1:0] acc;

  always_comb begin
    for (int m = 0; m < NUM_MACS; m++) begin
      prod[m] = PW'(a[m*DATA_WIDTH +: DATA_WIDTH])
              * PW'(b[m*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_comb begin
    dot = '0;
    for (int m = 0; m < NUM_MACS; m++) begin
      dot = dot + ACC_WIDTH'(prod[m]);
    end
  end

  // Clear wins over accumulate and ignores the enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (!rst_acc) begin
      acc <= '0;
    end else if (clk_en) begin
      acc <= acc + dot;
    end
  end

  assign result = acc[DATA_WIDTH-1:0];

endmodule

// File: rtl/pe_row.sv
// Row of independent PEs sharing broadcast operand b.
// Each PE sees its own a slice, enable bit and result lane.
module pe_row
  import pe_row_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int NUM_MACS        = DEF_NUM_MACS,
  parameter int NUM_PEs_PER_ROW = DEF_NUM_PES_PER_ROW,
  parameter int ACC_WIDTH       = DEF_ACC_WIDTH
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           rst_acc,
  input  logic [NUM_PEs_PER_ROW-1:0]                     clk_en,
  input  logic [NUM_PEs_PER_ROW*NUM_MACS*DATA_WIDTH-1:0] a,
  input  logic [NUM_MACS*DATA_WIDTH-1:0]                 b,
  output logic [NUM_PEs_PER_ROW*DATA_WIDTH-1:0]          result
);

  localparam int SW = NUM_MACS * DATA_WIDTH;

  generate
    for (genvar p = 0; p < NUM_PEs_PER_ROW; p++) begin : g_pe
      pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_MACS   (NUM_MACS),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk     (clk),
        .rst     (rst),
        .rst_acc (rst_acc),
        .clk_en  (clk_en[p]),
        .a       (a[p*SW +: SW]),
        .b       (b),
        .result  (result[p*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pe_row.sv
// Directed bench for pe_row with a scoreboard of expected lanes.
// Expected values are pushed when stimulus is set, popped after the edge.
module tb_pe_row;

  logic         clk;
  logic         rst;
  logic         rst_acc;
  logic [3:0]   clk_en;
  logic [127:0] a;
  logic [31:0]  b;
  logic [31:0]  result;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  tests;
  int  fails;

  pe_row dut (
    .clk     (clk),
    .rst     (rst),
    .rst_acc (rst_acc),
    .clk_en  (clk_en),
    .a       (a),
    .b       (b),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lanes(input int l3, input int l2,
                                        input int l1, input int l0);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // One active edge, then compare against the oldest expectation.
  task automatic step();
    sb_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty: observed %h expected entry", result);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, result, e.exp);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b0;
    rst_acc = 1'b1;
    clk_en  = 4'b1111;
    a       = '0;
    b       = '0;
    for (int i = 0; i < 16; i++) a[(15-i)*8 +: 8] = 8'(i + 1);
    b = {8'd1, 8'd2, 8'd3, 8'd4};

    // Reset held across an edge with enables active.
    @(posedge clk);
    #1;
    check("reset_hold", result, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_release", result, 32'h0);

    push("acc_e1", lanes(30, 70, 110, 150));
    step();
    push("acc_e2", lanes(60, 140, 220, 44));
    step();
    push("acc_e3", lanes(90, 210, 74, 194));
    step();

    // Back to edge-1 state, then gate lanes 1 and 3.
    @(negedge clk);
    rst_acc = 1'b0;
    clk_en  = 4'b0000;
    push("clr_a", 32'h0);
    step();
    @(negedge clk);
    rst_acc = 1'b1;
    clk_en  = 4'b1111;
    push("gate_e1", lanes(30, 70, 110, 150));
    step();
    @(negedge clk);
    clk_en = 4'b0101;
    push("gate_e2", lanes(30, 140, 110, 44));
    step();
    push("gate_e3", lanes(30, 210, 110, 194));
    step();

    // Clear has priority with all enables low.
    @(negedge clk);
    clk_en  = 4'b0000;
    rst_acc = 1'b0;
    push("clr_prio", 32'h0);
    step();
    @(negedge clk);
    rst_acc = 1'b1;
    clk_en  = 4'b1111;
    push("clr_resume", lanes(30, 70, 110, 150));
    step();

    // Asynchronous reset pulse between edges.
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst", result, 32'h0);
    #1;
    rst = 1'b1;
    push("async_resume", lanes(30, 70, 110, 150));
    step();

    // Maximum operands: no wrap inside the accumulator.
    @(negedge clk);
    rst_acc = 1'b0;
    push("max_clr", 32'h0);
    step();
    @(negedge clk);
    rst_acc = 1'b1;
    a       = '1;
    b       = '1;
    push("max_lanes", lanes(4, 4, 4, 4));
    step();
    check("max_acc0", dut.g_pe[0].u_pe.acc, 32'd260100);
    check("max_acc3", dut.g_pe[3].u_pe.acc, 32'd260100);

    tests++;
    assert (sb_q.size() == 0) else begin
      fails++;
      $error("FAIL sb_drain: observed %0d expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
